imem_responder: RTL and testbench

Memory-side responder for the instruction cache's miss interface. It accepts a word read request on `m_strobe`/`m_a` and, after a fixed latency, returns the word on `m_dout` with a one-cycle `m_ready` pulse. Storage is word-addressed RAM, filled through a separate load port by boot logic or the bench. It sits between the instruction cache and the off-core memory model, and stands in for the future bus bridge.

---
 rtl/imem_responder.sv | 113 +++++++++++
 tb/tb_imem_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Fixed-latency word-read responder for the instruction cache miss interface, with a RAM load port.
// Optional IMEM_RESP_ABORT_EN: abandon a pending read when the strobe drops or the word address changes.
module imem_responder #(
  parameter int unsigned A_WIDTH = 32,
  parameter int unsigned M_INDEX = 12,
  parameter int unsigned LATENCY = 3
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [A_WIDTH:0]   m_a,
  input  logic               m_strobe,
  output logic [31:0]        m_dout,
  output logic               m_ready,
  input  logic               ld_we,
  input  logic [A_WIDTH-1:0] ld_addr,
  input  logic [31:0]        ld_data
);

  localparam int unsigned DEPTH = 1 << M_INDEX;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [M_INDEX-1:0] cap_q, cap_d;
  logic [M_INDEX-1:0] req_idx, ld_idx, rd_idx;
  logic               ready_d;
  logic               dout_load;
  logic               abort_c;
  logic [31:0]        mem [DEPTH];

  assign req_idx = m_a[M_INDEX+1:2];
  assign ld_idx  = ld_addr[M_INDEX+1:2];

  // Only the word index is decoded; the remaining address bits alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m_a[A_WIDTH:M_INDEX+2], m_a[1:0],
                              ld_addr[A_WIDTH-1:M_INDEX+2], ld_addr[1:0]};

`ifdef IMEM_RESP_ABORT_EN
  assign abort_c = ~m_strobe | (req_idx != cap_q);
`else
  assign abort_c = 1'b0;
`endif

  // Next-state and registered-output decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cap_d     = cap_q;
    ready_d   = 1'b0;
    dout_load = 1'b0;
    rd_idx    = cap_q;
    case (state_q)
      IDLE: begin
        if (m_strobe) begin
          cap_d = req_idx;
          cnt_d = CNT_INIT;
          if (LATENCY == 1) begin
            state_d   = RESP;
            ready_d   = 1'b1;
            dout_load = 1'b1;
            rd_idx    = req_idx;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (abort_c) begin
          state_d = IDLE;
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d   = RESP;
          ready_d   = 1'b1;
          dout_load = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and response registers; RAM reads here see pre-write contents
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
      m_ready <= 1'b0;
      m_dout  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      m_ready <= ready_d;
      if (dout_load) begin
        m_dout <= mem[rd_idx];
      end
    end
  end

  // Load port; RAM is intentionally not reset
  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem[ld_idx] <= ld_data;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: three instances at LATENCY 3, 1 and 4.
module tb_imem_responder;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        clrn;
  logic [32:0] ma    [3];
  logic        stb   [3];
  logic [31:0] dout  [3];
  logic        rdy   [3];
  logic        we    [3];
  logic [31:0] la    [3];
  logic [31:0] ld    [3];

  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  imem_responder #(.A_WIDTH(32), .M_INDEX(12), .LATENCY(3)) u0 (
    .clk(clk), .clrn(clrn), .m_a(ma[0]), .m_strobe(stb[0]), .m_dout(dout[0]),
    .m_ready(rdy[0]), .ld_we(we[0]), .ld_addr(la[0]), .ld_data(ld[0]));
  imem_responder #(.A_WIDTH(32), .M_INDEX(12), .LATENCY(1)) u1 (
    .clk(clk), .clrn(clrn), .m_a(ma[1]), .m_strobe(stb[1]), .m_dout(dout[1]),
    .m_ready(rdy[1]), .ld_we(we[1]), .ld_addr(la[1]), .ld_data(ld[1]));
  imem_responder #(.A_WIDTH(32), .M_INDEX(12), .LATENCY(4)) u2 (
    .clk(clk), .clrn(clrn), .m_a(ma[2]), .m_strobe(stb[2]), .m_dout(dout[2]),
    .m_ready(rdy[2]), .ld_we(we[2]), .ld_addr(la[2]), .ld_data(ld[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int i);
    return (i == 0) ? 3 : (i == 1) ? 1 : 4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rsp(input int i, input logic [31:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic load(input int i, input logic [31:0] a, input logic [31:0] d);
    we[i] = 1'b1;
    la[i] = a;
    ld[i] = d;
    tick();
    we[i] = 1'b0;
  endtask

  // Single request; returns with the instance back in IDLE
  task automatic request(input int i, input logic [32:0] a, input logic [31:0] d);
    ma[i]  = a;
    stb[i] = 1'b1;
    expect_rsp(i, d, cyc + lat_of(i));
    tick();
    stb[i] = 1'b0;
    repeat (lat_of(i)) tick();
  endtask

  // Monitor: every m_ready pulse must match the head of its instance queue
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rdy[i] === 1'b1) begin
        exp_t e;
        int   found;
        found = 0;
        case (i)
          0:       if (q0.size() > 0) begin e = q0.pop_front(); found = 1; end
          1:       if (q1.size() > 0) begin e = q1.pop_front(); found = 1; end
          default: if (q2.size() > 0) begin e = q2.pop_front(); found = 1; end
        endcase
        total++;
        if (found == 0) begin
          bad++;
          $display("FAIL unexpected_ready inst%0d: got pulse data=%h cyc=%0d, required no pulse",
                   i, dout[i], cyc);
        end else if (dout[i] !== e.data || cyc != e.cyc) begin
          bad++;
          $display("FAIL rsp inst%0d: got data=%h cyc=%0d, required data=%h cyc=%0d",
                   i, dout[i], cyc, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    int n;
    clrn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ma[i] = '0; stb[i] = 1'b0; we[i] = 1'b0; la[i] = '0; ld[i] = '0;
    end
    repeat (3) tick();
    clrn = 1'b1;

    // Idle after reset: no pulses, zero data
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (rdy[i] !== 1'b0 || dout[i] !== 32'h0) begin
          bad++;
          $display("FAIL reset_idle inst%0d: got ready=%b dout=%h, required ready=0 dout=00000000",
                   i, rdy[i], dout[i]);
        end
      end
      tick();
    end

    // Basic read and high-bit aliasing
    load(0, 32'h0000_0040, 32'hDEAD_BEEF);
    request(0, 33'h0_0000_0040, 32'hDEAD_BEEF);
    request(0, 33'h1_F000_0040, 32'hDEAD_BEEF);

    // LATENCY=1 with strobe held: pulse every second cycle
    load(1, 32'h0000_0004, 32'hA5A5_0001);
    ma[1]  = 33'h4;
    stb[1] = 1'b1;
    n = cyc;
    for (int k = 0; k < 4; k++) expect_rsp(1, 32'hA5A5_0001, n + 1 + 2 * k);
    repeat (7) tick();
    stb[1] = 1'b0;
    repeat (2) tick();

    // Load write on the capture edge: old word returned, new word next time
    load(0, 32'h0000_0014, 32'h0000_1111);
    ma[0]  = 33'h14;
    stb[0] = 1'b1;
    expect_rsp(0, 32'h0000_1111, cyc + 3);
    tick();
    stb[0] = 1'b0;
    tick();
    we[0] = 1'b1; la[0] = 32'h14; ld[0] = 32'h0000_2222;
    tick();
    we[0] = 1'b0;
    tick();
    request(0, 33'h14, 32'h0000_2222);

    // Reset mid-request drops the response
    load(2, 32'h0000_001C, 32'h7777_0007);
    ma[2]  = 33'h1C;
    stb[2] = 1'b1;
    tick();
    stb[2] = 1'b0;
    clrn   = 1'b0;
    tick();
    total++;
    if (rdy[2] !== 1'b0 || dout[2] !== 32'h0) begin
      bad++;
      $display("FAIL mid_reset inst2: got ready=%b dout=%h, required ready=0 dout=00000000",
               rdy[2], dout[2]);
    end
    clrn = 1'b1;
    repeat (6) tick();
    request(2, 33'h1C, 32'h7777_0007);

    // Strobe dropped one cycle after acceptance
    load(0, 32'h0000_0080, 32'h8080_8080);
    ma[0]  = 33'h40;
    stb[0] = 1'b1;
    n = cyc;
`ifndef IMEM_RESP_ABORT_EN
    expect_rsp(0, 32'hDEAD_BEEF, n + 3);
`endif
    tick();
    stb[0] = 1'b0;
    repeat (4) tick();

    // Address changed with strobe held
    ma[0]  = 33'h40;
    stb[0] = 1'b1;
    n = cyc;
`ifdef IMEM_RESP_ABORT_EN
    expect_rsp(0, 32'h8080_8080, n + 5);
`else
    expect_rsp(0, 32'hDEAD_BEEF, n + 3);
    expect_rsp(0, 32'h8080_8080, n + 7);
`endif
    tick();
    ma[0] = 33'h80;
    repeat (4) tick();
    stb[0] = 1'b0;
    repeat (4) tick();

    // Every expected response must have been seen
    repeat (3) tick();
    total++;
    if (q0.size() != 0 || q1.size() != 0 || q2.size() != 0) begin
      bad++;
      $display("FAIL missing_rsp: got pending q0=%0d q1=%0d q2=%0d, required all 0",
               q0.size(), q1.size(), q2.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
